// File: rtl/adc_if_pkg.sv
// Shared types and default parameters for the parallel ADC/DAC pin interfaces.
package adc_if_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONVST    = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        READ      = 3'd4
    } state_t;

    localparam int DEF_DATA_W           = 14;
    localparam int DEF_CONVST_CYCLES    = 2;
    localparam int DEF_RD_ACCESS_CYCLES = 3;
    localparam int DEF_TIMEOUT_CYCLES   = 255;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status pin; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_parallel_reader.sv
// Drives a parallel-output SAR ADC through CONVST, BUSY handshake and a timed
// CS/RD read, presenting each captured word with a one-cycle valid pulse.
module adc_parallel_reader
    import adc_if_pkg::*;
#(
    parameter int DATA_W           = DEF_DATA_W,
    parameter int CONVST_CYCLES    = DEF_CONVST_CYCLES,
    parameter int RD_ACCESS_CYCLES = DEF_RD_ACCESS_CYCLES,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              adc_busy,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_convst_n,
    output logic              adc_cs_n,
    output logic              adc_rd_n,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_MAX = max3(TIMEOUT_CYCLES, CONVST_CYCLES, RD_ACCESS_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CONV_LOAD = CNT_W'(CONVST_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              convst_n_q, convst_n_d;
    logic              cs_n_q, cs_n_d;
    logic              rd_n_q, rd_n_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;
    logic              busy_s;

    sync_2ff u_busy_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (adc_busy),
        .q_o   (busy_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        convst_n_d = convst_n_q;
        cs_n_d     = cs_n_q;
        rd_n_d     = rd_n_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        terr_d     = terr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    convst_n_d = 1'b0;
                    busy_d     = 1'b1;
                    terr_d     = 1'b0;
                    cnt_d      = CONV_LOAD;
                    state_d    = CONVST;
                end
            end
            CONVST: begin
                if (cnt_q == '0) begin
                    convst_n_d = 1'b1;
                    state_d    = WAIT_RISE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            // Waiting for the rise first keeps a stale low BUSY from being read as "done".
            WAIT_RISE: begin
                if (busy_s) begin
                    cnt_d   = '0;
                    state_d = WAIT_FALL;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    terr_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_FALL: begin
                if (!busy_s) begin
                    cs_n_d  = 1'b0;
                    rd_n_d  = 1'b0;
                    cnt_d   = RD_LOAD;
                    state_d = READ;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d   = '0;
                    terr_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    sample_d = adc_data;
                    valid_d  = 1'b1;
                    cs_n_d   = 1'b1;
                    rd_n_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            convst_n_q <= 1'b1;
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            convst_n_q <= convst_n_d;
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
        end
    end

    assign adc_convst_n = convst_n_q;
    assign adc_cs_n     = cs_n_q;
    assign adc_rd_n     = rd_n_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_adc_parallel_reader.sv
// Bench for adc_parallel_reader: timeline model of each conversion derived from
// the BUSY waveform the bench itself drives, compared against the DUT every cycle.
module tb_adc_parallel_reader;

    localparam int DW = 14;
    localparam int C  = 2;
    localparam int RA = 3;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          adc_busy = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_convst_n, adc_cs_n, adc_rd_n;
    logic [DW-1:0] sample_out;
    logic          sample_valid, busy, timeout_err;

    adc_parallel_reader #(
        .DATA_W(DW), .CONVST_CYCLES(C), .RD_ACCESS_CYCLES(RA), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .adc_busy(adc_busy), .adc_data(adc_data),
        .adc_convst_n(adc_convst_n), .adc_cs_n(adc_cs_n), .adc_rd_n(adc_rd_n),
        .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; a value "at edge n" is what the DUT holds after edge n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: start accepted at edge m_T, outcome at edge m_end.
    // BUSY pin is high for the edges m_b0..m_b1 (inclusive).
    int            m_T = 0, m_end = 0, m_R = -1, m_F = 32'h4000_0000;
    int            m_b0 = 1, m_b1 = 0;
    bit            m_ok = 0, m_abort = 0, m_read = 0;
    logic [DW-1:0] m_data = '0, m_prev = '0;

    int n_checks = 0, n_err = 0;
    bit chk_en = 0;
    int conv_lo = 0, rd_lo = 0, vcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // The pin is driven for the next edge from the current BUSY window.
    always @(posedge clk) begin
        #2;
        adc_busy = (cyc + 1 >= m_b0) && (cyc + 1 <= m_b1);
    end

    always @(negedge clk) begin
        conv_lo += int'(!adc_convst_n);
        rd_lo   += int'(!adc_rd_n);
        vcnt    += int'(sample_valid);
        if (chk_en) begin
            int  n;
            bit  act;
            n   = cyc;
            act = (n >= m_T) && (n < m_end);
            chk("convst_n", adc_convst_n, !(act && n < m_T + C));
            chk("cs_n", adc_cs_n, !(act && m_read && n >= m_F));
            chk("rd_n", adc_rd_n, !(act && m_read && n >= m_F));
            chk("busy", busy, act);
            chk("sample_valid", sample_valid, m_ok && n == m_end);
            chk("timeout_err", timeout_err, m_abort && n >= m_end);
            chk("sample_out", sample_out, (m_ok && n >= m_end) ? m_data : m_prev);
        end
    end

    // The synchroniser makes the FSM see the pin two edges late.
    task automatic plan();
        int w0, r;
        w0 = m_T + C;
        m_read = 0; m_ok = 0; m_abort = 0; m_R = -1; m_F = 32'h4000_0000;
        if (m_b0 <= m_b1) begin
            r = (w0 + 1 > m_b0 + 2) ? w0 + 1 : m_b0 + 2;
            if (r <= m_b1 + 2 && r - w0 <= TO) m_R = r;
        end
        if (m_R < 0) begin
            m_abort = 1; m_end = w0 + TO;
        end else if (m_b1 + 3 - m_R <= TO) begin
            m_read = 1; m_ok = 1; m_F = m_b1 + 3; m_end = m_F + RA;
        end else begin
            m_abort = 1; m_end = m_R + TO;
        end
    endtask

    // mode: 0 normal pulse (d1 edges after CONVST, w edges wide), 1 BUSY stuck low, 2 stuck high.
    // rst_sel: 0 none, 1 on the 2nd rd-low cycle, 2 at a random edge inside the transaction.
    task automatic do_conv(input int mode, input int d1, input int w, input logic [DW-1:0] data,
                           input bit ign, input int rst_sel);
        logic [DW-1:0] prev;
        int rst_e, i2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        prev   = (m_ok && cyc >= m_end) ? m_data : m_prev;
        m_prev = prev;
        m_T    = cyc;
        m_data = data;
        adc_data = data;
        case (mode)
            1:       begin m_b0 = 1;              m_b1 = 0;            end
            2:       begin m_b0 = m_T + 1;        m_b1 = m_T + C + 300; end
            default: begin m_b0 = m_T + C + d1;   m_b1 = m_b0 + w - 1; end
        endcase
        plan();
        chk("accept_busy", busy, 1);
        chk("accept_terr_clear", timeout_err, 0);
        rst_e = -1;
        if (rst_sel == 1 && m_read) rst_e = m_F + 2;
        if (rst_sel == 2) rst_e = m_T + 1 + int'($urandom_range(0, m_end - m_T - 1));
        i2 = (m_R >= 0) ? m_R : m_T + C;
        while (cyc < m_end) begin
            start = ign && (cyc == m_T || cyc == i2);
            reset = (cyc + 1 == rst_e);
            @(posedge clk); #1;
            start = 1'b0;
            if (reset) begin
                reset = 1'b0;
                m_end = cyc; m_ok = 0; m_abort = 0; m_prev = '0;
            end
        end
    endtask

    task automatic settle(input int extra);
        while (cyc <= m_b1 + 4 || cyc <= m_end) begin
            @(posedge clk); #1;
        end
        repeat (extra) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0, v0, t1, e1, mode, r;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1;
        chk("reset_convst_n", adc_convst_n, 1);
        chk("reset_rd_n", adc_rd_n, 1);
        chk("reset_sample_out", sample_out, 0);
        chk("reset_busy", busy, 0);
        settle(2);

        // Normal read
        c0 = conv_lo; r0 = rd_lo; v0 = vcnt;
        do_conv(0, 1, 20, 14'h2A5C, 0, 0);
        chk("normal_latency", m_end - m_T, 28);
        settle(1);
        chk("normal_convst_lo", conv_lo - c0, 2);
        chk("normal_rd_lo", rd_lo - r0, 3);
        chk("normal_valid_cnt", vcnt - v0, 1);
        chk("normal_sample", sample_out, 14'h2A5C);
        chk("normal_busy_after", busy, 0);
        chk("normal_terr_after", timeout_err, 0);

        // Timeout, BUSY never rises
        r0 = rd_lo; v0 = vcnt;
        do_conv(1, 0, 0, 14'h1111, 0, 0);
        chk("tmo_low_latency", m_end - m_T, C + 255);
        chk("tmo_low_terr", timeout_err, 1);
        chk("tmo_low_busy", busy, 0);
        settle(1);
        chk("tmo_low_rd_lo", rd_lo - r0, 0);
        chk("tmo_low_valid", vcnt - v0, 0);
        chk("tmo_low_sample", sample_out, 14'h2A5C);

        // Timeout, BUSY stuck high; the next start clears the flag
        do_conv(2, 0, 0, 14'h2222, 0, 0);
        chk("tmo_high_latency", m_end - m_T, C + 1 + 255);
        chk("tmo_high_terr", timeout_err, 1);
        settle(1);

        // Boundary data, back-to-back
        v0 = vcnt;
        do_conv(0, 2, 5, 14'h3FFF, 0, 0);
        chk("b2b_first_sample", sample_out, 14'h3FFF);
        e1 = m_end;
        do_conv(0, 1, 7, 14'h0000, 0, 0);
        t1 = m_T;
        chk("b2b_accept_gap", t1 - e1, 1);
        settle(1);
        chk("b2b_valid_cnt", vcnt - v0, 2);
        chk("b2b_second_sample", sample_out, 14'h0000);

        // Ignored starts in CONVST and WAIT_FALL
        c0 = conv_lo; v0 = vcnt;
        do_conv(0, 3, 12, 14'h1357, 1, 0);
        settle(1);
        chk("ign_convst_lo", conv_lo - c0, 2);
        chk("ign_valid_cnt", vcnt - v0, 1);

        // Reset on the 2nd rd-low cycle, then a normal conversion
        v0 = vcnt;
        do_conv(0, 1, 10, 14'h0ABC, 0, 1);
        chk("rst_rd_n", adc_rd_n, 1);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sample", sample_out, 0);
        chk("rst_busy", busy, 0);
        settle(1);
        chk("rst_valid_cnt", vcnt - v0, 0);
        do_conv(0, 1, 10, 14'h0ABC, 0, 0);
        chk("rst_recover_sample", sample_out, 14'h0ABC);
        settle(1);

        // Randomised conversions, including the 255-cycle boundaries on each wait
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 19));
            mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            if (r == 2)
                do_conv(0, int'($urandom_range(1, 4)), int'($urandom_range(254, 257)),
                        DW'($urandom_range(0, 16383)), $urandom_range(0, 3) == 0, 0);
            else if (r == 3)
                do_conv(0, int'($urandom_range(251, 254)), 3,
                        DW'($urandom_range(0, 16383)), 0, 0);
            else
                do_conv(mode, int'($urandom_range(1, 8)), int'($urandom_range(1, 40)),
                        DW'($urandom_range(0, 16383)), $urandom_range(0, 3) == 0,
                        ($urandom_range(0, 7) == 0) ? 2 : 0);
            if (!(m_ok && $urandom_range(0, 1) == 1))
                settle(int'($urandom_range(0, 3)));
        end
        settle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
